// File: rtl/soc_sw_pkg.sv
// Shared constants and helpers for the slide-switch conditioning block.
package soc_sw_pkg;

  localparam int SW_WIDTH            = 8;
  localparam int SW_DEBOUNCE_DEFAULT = 50000;

  // Smallest r with 2**r >= value; sizes the per-bit stability counter.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_sw_debounce_bit.sv
// One switch bit: counts consecutive clocks of disagreement with the committed level
// and commits the new level once it has been stable for DEBOUNCE_CYCLES clocks.
module soc_sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic sw_out
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Any agreement with the committed level aborts the run; the terminal count always commits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      sw_out <= 1'b0;
    end else if (sync_in == sw_out) begin
      cnt <= '0;
    end else if (cnt >= TERM_CNT) begin
      sw_out <= sync_in;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/soc_sw_debounce.sv
// Synchronises and debounces the raw slide switches feeding the switch PIO in_port.
// Define SOC_SW_DEBOUNCE_EDGE_EN to generate sw_rise/sw_fall pulses; otherwise they are tied low.
module soc_sw_debounce
  import soc_sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // Synchroniser: sw_raw is read by nothing but the first stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .sync_in(sync_q[SYNC_STAGES-1][i]),
      .sw_out (sw_out[i])
    );
  end

`ifdef SOC_SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] prev;

  // Edge pulses appear one clock after the committed level changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
    end else begin
      prev    <= sw_out;
      sw_rise <= sw_out & ~prev;
      sw_fall <= ~sw_out & prev;
    end
  end
`else
  assign sw_rise = '0;
  assign sw_fall = '0;
`endif

endmodule

// File: tb/tb_soc_sw_debounce.sv
// Directed bench for soc_sw_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_soc_sw_debounce;

`ifdef SOC_SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] sw_raw = 8'h00;
  logic [7:0] sw_out, sw_rise, sw_fall;

  int n_cmp = 0;
  int n_bad = 0;

  soc_sw_debounce #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sw_raw (sw_raw),
    .sw_out (sw_out),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  logic [7:0] acc;
  logic       prev_o;
  int         ntrans;
  int         at_edge;

  initial begin
    // Reset held with all switches high
    reset_n = 1'b0;
    sw_raw  = 8'hFF;
    acc     = 8'h00;
    repeat (10) begin
      tick();
      acc |= sw_out | sw_rise | sw_fall;
    end
    chk("reset_any", acc, 8'h00);
    chk("reset_out", sw_out, 8'h00);
    chk("reset_rise", sw_rise, 8'h00);
    chk("reset_fall", sw_fall, 8'h00);
    sw_raw = 8'h00;
    #2 reset_n = 1'b1;
    settle(8);
    chk("idle_out", sw_out, 8'h00);

    // Clean step on bit 0
    sw_raw = 8'h01;
    acc    = 8'h00;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 6) acc |= sw_out;
    end
    chk("step_before_e6", acc, 8'h00);
    chk("step_e6", sw_out, 8'h01);
    chk("step_rise_e6", sw_rise, 8'h00);
    tick();
    chk("step_rise_e7", sw_rise, EDGE ? 8'h01 : 8'h00);
    tick();
    chk("step_rise_e8", sw_rise, 8'h00);
    chk("step_hold", sw_out, 8'h01);
    sw_raw = 8'h00;
    settle(10);
    chk("step_clear", sw_out, 8'h00);

    // Glitch of 3 clocks on bit 3 must be rejected
    acc    = 8'h00;
    sw_raw = 8'h08;
    repeat (3) begin
      tick();
      acc |= sw_out | sw_rise | sw_fall;
    end
    sw_raw = 8'h00;
    repeat (12) begin
      tick();
      acc |= sw_out | sw_rise | sw_fall;
    end
    chk("glitch3", acc, 8'h00);

    // 4 clocks high is just enough
    sw_raw = 8'h08;
    settle(4);
    sw_raw = 8'h00;
    settle(2);
    chk("glitch4_out", sw_out, 8'h08);
    settle(12);
    chk("glitch4_clear", sw_out, 8'h00);

    // Bounce on bit 0, then final toggle to 1
    prev_o  = sw_out[0];
    ntrans  = 0;
    at_edge = -1;
    for (int k = 0; k < 10; k++) begin
      sw_raw = (k % 2 == 0) ? 8'h01 : 8'h00;
      repeat (2) begin
        tick();
        if (sw_out[0] != prev_o) begin
          ntrans++;
          prev_o = sw_out[0];
        end
      end
    end
    sw_raw = 8'h01;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (sw_out[0] != prev_o) begin
        ntrans++;
        at_edge = e;
        prev_o  = sw_out[0];
      end
    end
    chk("bounce_ntrans", 8'(ntrans), 8'd1);
    chk("bounce_edge", 8'(at_edge), 8'd6);
    chk("bounce_out", sw_out, 8'h01);
    sw_raw = 8'h00;
    settle(10);

    // Multi-bit changes
    sw_raw = 8'hA5;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("multi_a5_e5", sw_out, 8'h00);
    end
    chk("multi_a5_e6", sw_out, 8'hA5);
    settle(4);
    sw_raw = 8'h5A;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("multi_5a_e5", sw_out, 8'hA5);
    end
    chk("multi_5a_e6", sw_out, 8'h5A);
    tick();
    chk("multi_rise", sw_rise, EDGE ? 8'h5A : 8'h00);
    chk("multi_fall", sw_fall, EDGE ? 8'hA5 : 8'h00);
    tick();
    chk("multi_rise_end", sw_rise, 8'h00);
    chk("multi_fall_end", sw_fall, 8'h00);

    // Reset in the middle of a filter run
    sw_raw = 8'h00;
    settle(10);
    chk("midrst_pre", sw_out, 8'h00);
    sw_raw = 8'hFF;
    settle(3);
    reset_n = 1'b0;
    tick();
    chk("midrst_in_reset", sw_out, 8'h00);
    reset_n = 1'b1;
    acc     = 8'h00;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 6) acc |= sw_out;
    end
    chk("midrst_before_e6", acc, 8'h00);
    chk("midrst_e6", sw_out, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
